multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ILLEGAL_HALT, default 1, meaning: 1 = an unsupported opcode parks the FSM in HALT; 0 = the instruction is skipped by returning to FETCH.
REQ-002 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port op, input, 7, instruction opcode bits [6:0] from the instruction register.
REQ-005 Port funct3, input, 3, instruction bits [14:12].
REQ-006 Port funct7b5, input, 1, instruction bit 30.
REQ-007 Port zero, input, 1, ALU zero flag.
REQ-008 Port pc_write, output, 1, PC load enable.
REQ-009 Port adr_src, output, 1, memory address select: 0 = PC, 1 = ALU result register.
REQ-010 Port mem_write, output, 1, data memory write enable.
REQ-011 Port ir_write, output, 1, instruction register load enable.
REQ-012 Port result_src, output, 2, result select: 00 = ALUOut, 01 = data, 10 = ALU result.
REQ-013 Port alu_src_a, output, 2, ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-014 Port alu_src_b, output, 2, ALU B select: 00 = rs2, 01 = immExt, 10 = constant 4.
REQ-015 Port imm_src, output, 2, sign-extender select: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 Port reg_write, output, 1, register file write enable.
REQ-017 Port alu_control, output, 3, ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 Port illegal, output, 1, sticky flag for an unsupported opcode.

Function
REQ-019 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ and HALT.
REQ-020 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR for lw (0000011) or sw (0100011), EXECR for 0110011, EXECI for 0010011, JAL for 1101111, BEQ for 1100011; MEMADR->MEMREAD for lw, MEMWRITE for sw; MEMREAD->MEMWB; MEMWB, MEMWRITE and BEQ ->FETCH; EXECR, EXECI and JAL ->ALUWB; ALUWB->FETCH; HALT->HALT.
REQ-021 An unsupported opcode in DECODE SHALL set illegal and go to HALT when ILLEGAL_HALT=1, or to FETCH when ILLEGAL_HALT=0.
REQ-022 Outputs SHALL be Moore per state; every signal not listed is 0:
- FETCH: ir_write=1, alu_src_b=10, result_src=10, pc_write=1.
- DECODE: alu_src_a=01, alu_src_b=01.
- MEMADR: alu_src_a=10, alu_src_b=01.
- MEMREAD: adr_src=1.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECR: alu_src_a=10, ALUOp=10.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10.
- ALUWB: reg_write=1.
- JAL: alu_src_a=01, alu_src_b=10, pc_write=1.
- BEQ: alu_src_a=10, ALUOp=01, pc_write=zero (combinational).
REQ-023 ALUOp decode SHALL be: 00 gives add; 01 gives sub; 10 decodes funct3 as 000 -> sub if funct7b5 and op[5] are both 1, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-024 imm_src SHALL be combinational from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
REQ-025 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
REQ-026 In HALT all enables (pc_write, ir_write, mem_write, reg_write) SHALL be 0.

Reset
REQ-027 rst_n low SHALL force FETCH and clear illegal immediately, regardless of clk and including mid-instruction.
REQ-028 While rst_n is low, all outputs SHALL equal their FETCH values with pc_write=0 and ir_write=0.
REQ-029 The first rising clk edge after rst_n rises SHALL execute FETCH.

Structure
REQ-030 The opcode constants, the state enumeration, and the ALUOp and alu_control encodings SHALL reside in a shared package, rv32i_ctrl_pkg.
REQ-031 The ALU decoder SHALL be one sub-module, alu_decoder (inputs ALUOp, funct3, funct7b5, op5; output alu_control); the FSM stays in multicycle_control.

Verification
REQ-032 Scenario lw: op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5; imm_src=00.
REQ-033 Scenario sw: op=0100011 -> mem_write=1 only in cycle 4, adr_src=1 in that cycle, imm_src=01.
REQ-034 Scenario beq: op=1100011 -> in BEQ, zero=1 gives pc_write=1 and zero=0 gives pc_write=0; alu_control=001; imm_src=10; back in FETCH at cycle 4.
REQ-035 Scenario R-type: op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECR; with funct3=111 -> alu_control=010.
REQ-036 Scenario illegal opcode: op=1111111 with ILLEGAL_HALT=1 -> HALT with illegal=1 and all enables 0; rst_n pulse -> FETCH with illegal=0.
REQ-037 Scenario reset mid-instruction: assert rst_n low during MEMREAD -> state becomes FETCH asynchronously, before the next clk edge.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, FSM states,
// ALUOp classes, ALU operation codes and datapath mux selects.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp class plus instruction function fields onto the
// concrete ALU operation code.
module alu_decoder
    import rv32i_ctrl_pkg::*;
(
    input  aluop_e     alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means subtract for R-type; addi reuses bit 30 as immediate
                    3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style main controller for the multicycle RV32I datapath; the ALU
// operation itself is resolved in alu_decoder.
module multicycle_control
    import rv32i_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    aluop_e alu_op;
    logic   pc_write_s;
    logic   ir_write_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_s = 1'b0;
        ir_write_s = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                pc_write_s = zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    // Reset forces FETCH asynchronously, but the PC and IR must not load while held
    assign pc_write = pc_write_s & rst_n;
    assign ir_write = ir_write_s & rst_n;
    assign illegal  = illegal_q;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table vectors, randomized instruction stream
// against a per-instruction step model, and reset/illegal/branch sequences.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic       regw;
        logic [2:0] aluc;
    } ctl_t;

    typedef struct {
        ctl_t c;
        logic z;
    } step_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        logic [1:0] imm;
        logic [2:0] aluKey;
        logic       pcwKey;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pcWrite1, adrSrc1, memWrite1, irWrite1, regWrite1, illegal1;
    logic [1:0] resultSrc1, aluSrcA1, aluSrcB1, immSrc1;
    logic [2:0] aluControl1;
    logic       pcWrite0, adrSrc0, memWrite0, irWrite0, regWrite0, illegal0;
    logic [1:0] resultSrc0, aluSrcA0, aluSrcB0, immSrc0;
    logic [2:0] aluControl0;

    ctl_t act1, act0;
    int checks   = 0;
    int failures = 0;
    step_t expQ[$];
    vec_t  vecs[13];
    logic [6:0] legalOps[6];

    assign act1 = {pcWrite1, adrSrc1, memWrite1, irWrite1, resultSrc1, aluSrcA1, aluSrcB1, regWrite1, aluControl1};
    assign act0 = {pcWrite0, adrSrc0, memWrite0, irWrite0, resultSrc0, aluSrcA0, aluSrcB0, regWrite0, aluControl0};

    multicycle_control #(.ILLEGAL_HALT(1'b1)) dutHalt (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(pcWrite1), .adr_src(adrSrc1), .mem_write(memWrite1), .ir_write(irWrite1),
        .result_src(resultSrc1), .alu_src_a(aluSrcA1), .alu_src_b(aluSrcB1), .imm_src(immSrc1),
        .reg_write(regWrite1), .alu_control(aluControl1), .illegal(illegal1)
    );

    multicycle_control #(.ILLEGAL_HALT(1'b0)) dutSkip (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(pcWrite0), .adr_src(adrSrc0), .mem_write(memWrite0), .ir_write(irWrite0),
        .result_src(resultSrc0), .alu_src_a(aluSrcA0), .alu_src_b(aluSrcB0), .imm_src(immSrc0),
        .reg_write(regWrite0), .alu_control(aluControl0), .illegal(illegal0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still ends with a visible failure
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ctl_t mk(input logic pcw, input logic adr, input logic memw, input logic irw,
                                input logic [1:0] res, input logic [1:0] srcA, input logic [1:0] srcB,
                                input logic regw, input logic [2:0] aluc);
        ctl_t c;
        c = {pcw, adr, memw, irw, res, srcA, srcB, regw, aluc};
        return c;
    endfunction

    function automatic logic [2:0] aluFunct(input logic [2:0] f3, input logic f7, input logic op5);
        if (f3 == 3'b000) return (f7 && op5) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic [1:0] immFor(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic ctl_t fetchCtl();
        return mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'b000);
    endfunction

    function automatic ctl_t resetCtl();
        return mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b000);
    endfunction

    function automatic ctl_t decodeCtl();
        return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000);
    endfunction

    task automatic pushStep(input ctl_t c, input logic z);
        step_t s;
        s.c = c;
        s.z = z;
        expQ.push_back(s);
    endtask

    // Expected per-cycle control words for one whole instruction, FETCH first
    task automatic buildExpected(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        logic z;
        logic [2:0] fa;
        fa = aluFunct(f3, f7, o[5]);
        expQ.delete();
        pushStep(fetchCtl(), 1'($urandom_range(0, 1)));
        pushStep(decodeCtl(), 1'($urandom_range(0, 1)));
        case (o)
            7'b0000011: begin
                pushStep(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000), 1'($urandom_range(0, 1)));
                pushStep(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000), 1'($urandom_range(0, 1)));
                pushStep(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000), 1'($urandom_range(0, 1)));
            end
            7'b0100011: begin
                pushStep(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000), 1'($urandom_range(0, 1)));
                pushStep(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000), 1'($urandom_range(0, 1)));
            end
            7'b0110011: begin
                pushStep(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, fa), 1'($urandom_range(0, 1)));
                pushStep(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000), 1'($urandom_range(0, 1)));
            end
            7'b0010011: begin
                pushStep(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, fa), 1'($urandom_range(0, 1)));
                pushStep(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000), 1'($urandom_range(0, 1)));
            end
            7'b1101111: begin
                pushStep(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000), 1'($urandom_range(0, 1)));
                pushStep(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000), 1'($urandom_range(0, 1)));
            end
            default: begin
                z = 1'($urandom_range(0, 1));
                pushStep(mk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001), z);
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        buildExpected(o, f3, f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        for (int i = 0; i < expQ.size(); i++) begin
            zero = expQ[i].z;
            #1;
            checkOutput($sformatf("rand op=%b step%0d ctl haltdut", o, i), {2'b00, act1}, {2'b00, expQ[i].c});
            checkOutput($sformatf("rand op=%b step%0d ctl skipdut", o, i), {2'b00, act0}, {2'b00, expQ[i].c});
            checkOutput($sformatf("rand op=%b step%0d imm_src", o, i), {14'd0, immSrc1}, {14'd0, immFor(o)});
            checkOutput($sformatf("rand op=%b step%0d illegal", o, i), {14'd0, illegal1, illegal0}, 16'd0);
            @(negedge clk);
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int lat;
        lat      = 0;
        op       = v.op;
        funct3   = v.f3;
        funct7b5 = v.f7;
        zero     = v.z;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c == 1) begin
                checkOutput($sformatf("vec%0d imm_src", idx), {14'd0, immSrc1}, {14'd0, v.imm});
                checkOutput($sformatf("vec%0d ir_write in fetch", idx), {15'd0, irWrite1}, 16'd1);
            end
            if (c == 3) begin
                checkOutput($sformatf("vec%0d alu_control cycle3", idx), {13'd0, aluControl1}, {13'd0, v.aluKey});
                checkOutput($sformatf("vec%0d alu_control cycle3 skipdut", idx), {13'd0, aluControl0}, {13'd0, v.aluKey});
                checkOutput($sformatf("vec%0d pc_write cycle3", idx), {15'd0, pcWrite1}, {15'd0, v.pcwKey});
            end
            if (c > 1 && irWrite1 === 1'b1) begin
                lat = c - 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput($sformatf("vec%0d latency", idx), 16'(lat), 16'(v.lat));
        checkOutput($sformatf("vec%0d skipdut back in fetch", idx), {15'd0, irWrite0}, 16'd1);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        op       = 7'd0;
        funct3   = 3'd0;
        funct7b5 = 1'b0;
        zero     = 1'b0;

        vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 2'b00, 3'b000, 1'b0};
        vecs[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 2'b01, 3'b000, 1'b0};
        vecs[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 2'b00, 3'b000, 1'b0};
        vecs[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b1, 4, 2'b00, 3'b001, 1'b0};
        vecs[4]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 2'b00, 3'b010, 1'b0};
        vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 2'b00, 3'b011, 1'b0};
        vecs[6]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 2'b00, 3'b101, 1'b0};
        vecs[7]  = '{7'b0110011, 3'b100, 1'b1, 1'b0, 4, 2'b00, 3'b000, 1'b0};
        vecs[8]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 2'b00, 3'b000, 1'b0};
        vecs[9]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4, 2'b00, 3'b101, 1'b0};
        vecs[10] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 2'b11, 3'b000, 1'b1};
        vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 2'b10, 3'b001, 1'b1};
        vecs[12] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 2'b10, 3'b001, 1'b0};

        legalOps = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

        #2;
        checkOutput("reset ctl", {2'b00, act1}, {2'b00, resetCtl()});
        checkOutput("reset illegal", {14'd0, illegal1, illegal0}, 16'd0);
        @(posedge clk);
        #1;
        checkOutput("reset held across edge", {2'b00, act1}, {2'b00, resetCtl()});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) runVector(vecs[i], i);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(legalOps[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        // beq: pc_write follows zero combinationally inside the BEQ state
        op = 7'b1100011;
        zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        zero = 1'b1;
        #1;
        checkOutput("beq zero=1 pc_write", {15'd0, pcWrite1}, 16'd1);
        zero = 1'b0;
        #1;
        checkOutput("beq zero=0 pc_write", {15'd0, pcWrite1}, 16'd0);
        @(negedge clk);
        #1;
        checkOutput("beq back in fetch", {2'b00, act1}, {2'b00, fetchCtl()});

        // reset asserted while a load sits in MEMREAD
        op = 7'b0000011;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("lw memread adr_src", {15'd0, adrSrc1}, 16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset mid memread haltdut", {2'b00, act1}, {2'b00, resetCtl()});
        checkOutput("async reset mid memread skipdut", {2'b00, act0}, {2'b00, resetCtl()});
        @(posedge clk);
        #1;
        checkOutput("reset held mid instr", {2'b00, act1}, {2'b00, resetCtl()});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("after release fetch", {2'b00, act1}, {2'b00, fetchCtl()});
        @(negedge clk);
        #1;
        checkOutput("first edge executes fetch", {2'b00, act1}, {2'b00, decodeCtl()});
        pulseReset();

        // unsupported opcode: one instance parks in HALT, the other skips
        op = 7'b1111111;
        #1;
        checkOutput("illegal op fetch", {2'b00, act1}, {2'b00, fetchCtl()});
        @(negedge clk);
        #1;
        checkOutput("illegal op decode", {2'b00, act1}, {2'b00, decodeCtl()});
        checkOutput("illegal not yet set", {14'd0, illegal1, illegal0}, 16'd0);
        @(negedge clk);
        #1;
        checkOutput("halt ctl zero", {2'b00, act1}, 16'd0);
        checkOutput("halt illegal set", {15'd0, illegal1}, 16'd1);
        checkOutput("halt imm_src other", {14'd0, immSrc1}, 16'd0);
        checkOutput("skip returns to fetch", {2'b00, act0}, {2'b00, fetchCtl()});
        checkOutput("skip illegal set", {15'd0, illegal0}, 16'd1);
        @(negedge clk);
        #1;
        checkOutput("halt stays", {2'b00, act1}, 16'd0);
        checkOutput("skip decode again", {2'b00, act0}, {2'b00, decodeCtl()});
        @(negedge clk);
        #1;
        checkOutput("halt still stays", {2'b00, act1}, 16'd0);
        checkOutput("skip fetch again", {2'b00, act0}, {2'b00, fetchCtl()});
        checkOutput("illegal sticky", {14'd0, illegal1, illegal0}, 16'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("reset clears illegal", {14'd0, illegal1, illegal0}, 16'd0);
        checkOutput("reset leaves halt", {2'b00, act1}, {2'b00, resetCtl()});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("fetch after halt reset", {2'b00, act1}, {2'b00, fetchCtl()});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
